// File: rtl/alloc_sched_pkg.sv
// Shared types for the allocation-stage scheduler: ROB id width and queue entry layout.
package alloc_sched_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int PAYLOAD_W = 64;
  localparam int ROBID_W   = $clog2(ROB_DEPTH);

  typedef logic [ROBID_W-1:0] t_rob_id;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic                 mm;
    t_rob_id              robid;
  } t_alloc_q_entry;

endpackage

// File: rtl/alloc_queue.sv
// Two-entry in-order allocation FIFO; head visible combinationally, clear beats push/pop.
module alloc_queue
  import alloc_sched_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           push_i,
  input  t_alloc_q_entry push_dat_i,
  input  logic           pop_i,
  input  logic           clear_i,
  output logic           head_vld_o,
  output t_alloc_q_entry head_dat_o,
  output logic [1:0]     count_o
);

  t_alloc_q_entry mem_q [2];
  logic           rd_ptr_q, rd_ptr_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic [1:0]     count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_vld_o = (count_q != 2'd0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    !(push_i && !clear_i && count_q == 2'd2));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
    !(pop_i && !clear_i && count_q == 2'd0));

endmodule

// File: rtl/alloc_sched.sv
// Assigns ROB ids to decoded uops, buffers them in order and steers the head to the EX or MM RS.
// stall_de1 depends only on registered queue/ROB occupancy; flush clears everything except next_robid.
module alloc_sched #(
  parameter  int ROB_DEPTH = alloc_sched_pkg::ROB_DEPTH,
  parameter  int PAYLOAD_W = alloc_sched_pkg::PAYLOAD_W,
  localparam int ROBID_W   = $clog2(ROB_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uinstr_valid_de1,
  input  logic                 uinstr_mm_de1,
  input  logic [PAYLOAD_W-1:0] uinstr_payload_de1,
  output logic                 stall_de1,
  output logic [ROBID_W-1:0]   next_robid_ra0,
  output logic [ROBID_W:0]     rob_count_ra0,
  input  logic                 rs_stall_ex_rs0,
  input  logic                 rs_stall_mm_rs0,
  output logic                 disp_valid_ex_rs1,
  output logic                 disp_valid_mm_rs1,
  output logic [PAYLOAD_W-1:0] disp_payload_rs1,
  output logic [ROBID_W-1:0]   disp_robid_rs1,
  input  logic                 retire_valid,
  input  logic                 flush
);
  import alloc_sched_pkg::*;

  logic           q_head_vld;
  t_alloc_q_entry q_head;
  t_alloc_q_entry q_push_dat;
  logic [1:0]     q_count;

  logic                 accept, go, retire_ok, head_blocked;
  logic [ROBID_W-1:0]   next_robid_q, next_robid_d;
  logic [ROBID_W:0]     rob_count_q, rob_count_d;
  logic                 disp_vld_ex_q, disp_vld_ex_d;
  logic                 disp_vld_mm_q, disp_vld_mm_d;
  logic [PAYLOAD_W-1:0] disp_payload_q, disp_payload_d;
  logic [ROBID_W-1:0]   disp_robid_q, disp_robid_d;

  assign stall_de1    = (q_count == 2'd2) | (rob_count_q == (ROBID_W+1)'(ROB_DEPTH));
  assign accept       = uinstr_valid_de1 & ~stall_de1 & ~flush;
  // Strict in-order: only the head's own target stall matters; the second entry waits behind it.
  assign head_blocked = q_head.mm ? rs_stall_mm_rs0 : rs_stall_ex_rs0;
  assign go           = q_head_vld & ~head_blocked & ~flush;
  assign retire_ok    = retire_valid & (rob_count_q != '0) & ~flush;

  always_comb begin
    q_push_dat         = '0;
    q_push_dat.payload = uinstr_payload_de1;
    q_push_dat.mm      = uinstr_mm_de1;
    q_push_dat.robid   = next_robid_q;
  end

  alloc_queue u_alloc_queue (
    .clk        (clk),
    .reset      (reset),
    .push_i     (accept),
    .push_dat_i (q_push_dat),
    .pop_i      (go),
    .clear_i    (flush),
    .head_vld_o (q_head_vld),
    .head_dat_o (q_head),
    .count_o    (q_count)
  );

  always_comb begin
    next_robid_d   = next_robid_q + ROBID_W'(accept);
    rob_count_d    = rob_count_q + (ROBID_W+1)'(accept) - (ROBID_W+1)'(retire_ok);
    disp_vld_ex_d  = go & ~q_head.mm;
    disp_vld_mm_d  = go & q_head.mm;
    disp_payload_d = disp_payload_q;
    disp_robid_d   = disp_robid_q;
    if (go) begin
      disp_payload_d = q_head.payload;
      disp_robid_d   = q_head.robid;
    end
    if (flush) rob_count_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_robid_q   <= '0;
      rob_count_q    <= '0;
      disp_vld_ex_q  <= 1'b0;
      disp_vld_mm_q  <= 1'b0;
      disp_payload_q <= '0;
      disp_robid_q   <= '0;
    end else begin
      next_robid_q   <= next_robid_d;
      rob_count_q    <= rob_count_d;
      disp_vld_ex_q  <= disp_vld_ex_d;
      disp_vld_mm_q  <= disp_vld_mm_d;
      disp_payload_q <= disp_payload_d;
      disp_robid_q   <= disp_robid_d;
    end
  end

  assign next_robid_ra0    = next_robid_q;
  assign rob_count_ra0     = rob_count_q;
  assign disp_valid_ex_rs1 = disp_vld_ex_q;
  assign disp_valid_mm_rs1 = disp_vld_mm_q;
  assign disp_payload_rs1  = disp_payload_q;
  assign disp_robid_rs1    = disp_robid_q;

  a_one_disp: assert property (@(posedge clk) disable iff (!reset)
    !(disp_vld_ex_q && disp_vld_mm_q));
  a_rob_bound: assert property (@(posedge clk) disable iff (!reset)
    rob_count_q <= (ROBID_W+1)'(ROB_DEPTH));
  a_retire_empty: assert property (@(posedge clk) disable iff (!reset)
    !(retire_valid && rob_count_q == '0));

endmodule

// File: tb/tb_alloc_sched.sv
// Randomized and directed bench for alloc_sched: a queue-based reference model predicts each dispatch
// and its cycle; a separate monitor compares DUT dispatches against the expected queue.
module tb_alloc_sched;

  localparam int ROB_DEPTH = 16;
  localparam int PW        = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          uinstr_valid_de1, uinstr_mm_de1;
  logic [PW-1:0] uinstr_payload_de1;
  logic          stall_de1;
  logic [3:0]    next_robid_ra0;
  logic [4:0]    rob_count_ra0;
  logic          rs_stall_ex_rs0, rs_stall_mm_rs0;
  logic          disp_valid_ex_rs1, disp_valid_mm_rs1;
  logic [PW-1:0] disp_payload_rs1;
  logic [3:0]    disp_robid_rs1;
  logic          retire_valid, flush;

  always #5 clk = ~clk;

  alloc_sched dut (
    .clk                (clk),
    .reset              (reset),
    .uinstr_valid_de1   (uinstr_valid_de1),
    .uinstr_mm_de1      (uinstr_mm_de1),
    .uinstr_payload_de1 (uinstr_payload_de1),
    .stall_de1          (stall_de1),
    .next_robid_ra0     (next_robid_ra0),
    .rob_count_ra0      (rob_count_ra0),
    .rs_stall_ex_rs0    (rs_stall_ex_rs0),
    .rs_stall_mm_rs0    (rs_stall_mm_rs0),
    .disp_valid_ex_rs1  (disp_valid_ex_rs1),
    .disp_valid_mm_rs1  (disp_valid_mm_rs1),
    .disp_payload_rs1   (disp_payload_rs1),
    .disp_robid_rs1     (disp_robid_rs1),
    .retire_valid       (retire_valid),
    .flush              (flush)
  );

  typedef struct {
    logic [PW-1:0] payload;
    bit            mm;
    int            robid;
  } uop_t;

  typedef struct {
    logic [PW-1:0] payload;
    bit            mm;
    int            robid;
    int            cyc;
  } exp_t;

  uop_t mq[$];
  exp_t expq[$];
  int   mrob   = 0;
  int   mnext  = 0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: compare visible state with the model, drive inputs, advance the model to the next edge.
  task automatic step(input bit vld, input bit mm, input logic [PW-1:0] pl,
                      input bit sex, input bit smm, input bit ret, input bit fl);
    bit   mstall, acc, go, rt;
    uop_t u;
    exp_t e;
    mstall = (mq.size() == 2) || (mrob == ROB_DEPTH);
    chk("stall_de1", stall_de1, mstall);
    chk("next_robid", next_robid_ra0, mnext);
    chk("rob_count", rob_count_ra0, mrob);
    if (mrob == 0) ret = 0;
    uinstr_valid_de1   = vld;
    uinstr_mm_de1      = mm;
    uinstr_payload_de1 = pl;
    rs_stall_ex_rs0    = sex;
    rs_stall_mm_rs0    = smm;
    retire_valid       = ret;
    flush              = fl;
    acc = vld && !mstall && !fl;
    go  = !fl && (mq.size() > 0) && !(mq[0].mm ? smm : sex);
    rt  = ret && !fl;
    if (go) begin
      u = mq.pop_front();
      e.payload = u.payload; e.mm = u.mm; e.robid = u.robid; e.cyc = cyc + 1;
      expq.push_back(e);
    end
    if (fl) mq.delete();
    if (acc) begin
      u.payload = pl; u.mm = mm; u.robid = mnext;
      mq.push_back(u);
      mnext = (mnext + 1) % ROB_DEPTH;
    end
    mrob = fl ? 0 : mrob + int'(acc) - int'(rt);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
          e = expq.pop_front();
          checks++; errors++;
          $display("FAIL missing_dispatch: robid %0d due cycle %0d not seen by cycle %0d", e.robid, e.cyc, cyc);
        end
        if (disp_valid_ex_rs1 || disp_valid_mm_rs1) begin
          chk("both_valids", disp_valid_ex_rs1 & disp_valid_mm_rs1, 1'b0);
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_dispatch: robid %0h payload %0h at cycle %0d", disp_robid_rs1, disp_payload_rs1, cyc);
          end else begin
            e = expq.pop_front();
            chk("disp_cycle", cyc, e.cyc);
            chk("disp_mm", disp_valid_mm_rs1, e.mm);
            chk("disp_ex", disp_valid_ex_rs1, !e.mm);
            chk("disp_payload", disp_payload_rs1, e.payload);
            chk("disp_robid", disp_robid_rs1, e.robid);
          end
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0;
    uinstr_valid_de1 = 0; uinstr_mm_de1 = 0; uinstr_payload_de1 = '0;
    rs_stall_ex_rs0 = 0; rs_stall_mm_rs0 = 0; retire_valid = 0; flush = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall_de1, 1'b0);
    chk("rst_vld_ex", disp_valid_ex_rs1, 1'b0);
    chk("rst_vld_mm", disp_valid_mm_rs1, 1'b0);
    chk("rst_payload", disp_payload_rs1, '0);
    chk("rst_robid", disp_robid_rs1, '0);
    chk("rst_next_robid", next_robid_ra0, '0);
    chk("rst_rob_count", rob_count_ra0, '0);
    reset = 1'b1;
    @(negedge clk);

    // single EX uop, latency 2
    step(1, 0, 64'hA5, 0, 0, 0, 0);
    idle(3);

    // four back-to-back alternating EX/MM
    for (int i = 0; i < 4; i++) step(1, i[0], 64'h100 + 64'(i), 0, 0, 0, 0);
    idle(3);

    // EX stalled head blocks an MM second entry; decode back-pressured once two are queued
    step(1, 0, 64'hE0, 1, 0, 0, 0);
    step(1, 1, 64'hE1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 64'hDEAD, 1, 0, 0, 0);
    idle(4);

    // fill the ROB, then a single retire frees one slot and the wrapped id is reused
    for (int i = 0; i < 20; i++) step(1, 1'($urandom), {$urandom, $urandom}, 0, 0, 0, 0);
    step(1, 0, 64'hBEEF, 0, 0, 1, 0);
    step(1, 0, 64'hCAFE, 0, 0, 0, 0);
    idle(3);

    // accept and retire together at a fixed occupancy
    while (mrob > 5) step(0, 0, '0, 0, 0, 1, 0);
    step(1, 1, 64'h55, 0, 0, 1, 0);
    idle(3);

    // flush with two queued, seven allocated and a fresh offer in the same cycle
    while (mrob > 5) step(0, 0, '0, 0, 0, 1, 0);
    step(1, 0, 64'hF0, 1, 1, 0, 0);
    step(1, 1, 64'hF1, 1, 1, 0, 0);
    step(1, 0, 64'hF2, 1, 1, 0, 1);
    idle(4);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(3, 0) != 0, 1'($urandom), {$urandom, $urandom},
           $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
           $urandom_range(2, 0) == 0, $urandom_range(63, 0) == 0);

    for (int i = 0; i < 24; i++) step(0, 0, '0, 0, 0, 1, 0);
    chk("scoreboard_empty", 64'(expq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
